// File: rtl/demux_pkg.sv
// Shared constants and types for the buffered 1-to-4 demultiplexer.
// The broadcast option is controlled by the DEMUX4X32_BCAST_EN macro in the top level.
package demux_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_DEPTH = 2;
  localparam int NCH       = 4;

  typedef logic [1:0] sel_t;

  // One-hot destination mask for a channel select.
  function automatic logic [NCH-1:0] sel_decode(input sel_t sel);
    logic [NCH-1:0] one;
    one = {{(NCH-1){1'b0}}, 1'b1};
    return one << sel;
  endfunction

endpackage

// File: rtl/fifo_slot.sv
// One DEPTH x WIDTH synchronous FIFO channel with registered head and async active-low clear.
// Push into a full slot or pop from an empty one is ignored.
module fifo_slot
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int DEPTH = DEF_DEPTH,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_push && !do_pop)      count_d = count_q + CW'(1);
    else if (!do_push && do_pop) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = empty ? '0 : mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/demux4x32_buf.sv
// Buffered 1-to-4 demultiplexer: steers each accepted word into one of four FIFO channels.
// Defining DEMUX4X32_BCAST_EN adds the bc input, which pushes one word into all four channels.
module demux4x32_buf
  import demux_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic [WIDTH-1:0] d,
  input  sel_t             s,
  input  logic             ivalid,
  output logic             iready,
`ifdef DEMUX4X32_BCAST_EN
  input  logic             bc,
`endif
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1,
  output logic [WIDTH-1:0] y2,
  output logic [WIDTH-1:0] y3,
  output logic [NCH-1:0]   ovalid,
  input  logic [NCH-1:0]   oready
);

  logic [NCH-1:0]   dest;
  logic [NCH-1:0]   full_w;
  logic [NCH-1:0]   empty_w;
  logic [NCH-1:0]   push_w;
  logic [WIDTH-1:0] head_w [NCH];

`ifdef DEMUX4X32_BCAST_EN
  assign dest = bc ? {NCH{1'b1}} : sel_decode(s);
`else
  assign dest = sel_decode(s);
`endif

  // Ready depends only on the select and registered fill levels, never on oready.
  assign iready = clrn & ~|(full_w & dest);
  assign push_w = {NCH{ivalid & iready}} & dest;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    logic [$clog2(DEPTH):0] level_unused;

    fifo_slot #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_slot (
      .clk   (clk),
      .clrn  (clrn),
      .push  (push_w[gi]),
      .pop   (oready[gi]),
      .wdata (d),
      .full  (full_w[gi]),
      .empty (empty_w[gi]),
      .head  (head_w[gi]),
      .count (level_unused)
    );

    assign ovalid[gi] = ~empty_w[gi];
  end

  assign y0 = head_w[0];
  assign y1 = head_w[1];
  assign y2 = head_w[2];
  assign y3 = head_w[3];

endmodule
